// File: rtl/alu_seq.sv
// Purpose : W-bit handshaked ALU, 8 single-cycle ops, shift-add unsigned multiply, illegal-opcode flag.
// Latency : non-mul result registered on the accept edge; mul result W edges after accept.
// Backpr. : in_ready drops while busy or while an unconsumed result is held; result holds until out_ready.
module alu_seq #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   sel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic         carry,
    output logic         zero,
    output logic         overflow,
    output logic         err,
    output logic         busy
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_NOT = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd6;
    localparam logic [3:0] OP_EQ  = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [2*W-1:0] mcand;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_step;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;

    logic           accept;
    logic           accept_mul;
    logic           accept_alu;
    logic           mul_last;

    logic [W:0]     add_w;
    logic [W:0]     sub_w;
    logic [W-1:0]   alu_s;
    logic           alu_c;
    logic           alu_o;
    logic           alu_e;

    assign busy       = (state == ST_MUL);
    assign in_ready   = rst_n && !busy && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign accept_mul = accept && (sel == OP_MUL);
    assign accept_alu = accept && (sel != OP_MUL);
    assign mul_last   = busy && (cnt == CW'(W - 1));

    // Shared adder paths; subtraction is a + ~b + 1 so carry-out set means no borrow.
    assign add_w    = {1'b0, a} + {1'b0, b};
    assign sub_w    = {1'b0, a} + {1'b0, ~b} + (W + 1)'(1);
    assign acc_step = mplier[0] ? (acc + mcand) : acc;

    // Single-cycle result and flags for every opcode except multiply.
    always_comb begin
        alu_s = '0;
        alu_c = 1'b0;
        alu_o = 1'b0;
        alu_e = 1'b0;
        case (sel)
            OP_ADD: begin
                alu_s = add_w[W-1:0];
                alu_c = add_w[W];
                alu_o = (a[W-1] == b[W-1]) && (add_w[W-1] != a[W-1]);
            end
            OP_SUB: begin
                alu_s = sub_w[W-1:0];
                alu_c = !sub_w[W];
                alu_o = (a[W-1] != b[W-1]) && (sub_w[W-1] != a[W-1]);
            end
            OP_NOT: alu_s = ~a;
            OP_AND: alu_s = a & b;
            OP_OR:  alu_s = a | b;
            OP_XOR: alu_s = a ^ b;
            OP_SLT: alu_s = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_EQ:  alu_s = {{(W-1){1'b0}}, (a == b)};
            OP_MUL: alu_s = '0;
            default: alu_e = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: enter MUL on a multiply accept, leave after the W-th step.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept_mul) state_nxt = ST_MUL;
            ST_MUL:  if (mul_last)   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Multiply datapath: load on accept, then one multiplier bit per edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (accept_mul) begin
            mcand  <= {{W{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
            cnt    <= '0;
        end else if (busy) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

    // Output slot: a new completion overwrites, a consume without completion empties it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
        end else if (accept_alu) begin
            out_valid <= 1'b1;
            s         <= alu_s;
            carry     <= alu_c;
            zero      <= (alu_s == '0);
            overflow  <= alu_o;
            err       <= alu_e;
        end else if (mul_last) begin
            out_valid <= 1'b1;
            s         <= acc_step[W-1:0];
            carry     <= 1'b0;
            zero      <= (acc_step[W-1:0] == '0);
            overflow  <= |acc_step[2*W-1:W];
            err       <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
